collision_scheduler: RTL

COLLISION_SCHEDULER -- requirements
Module: collision_scheduler

---
 rtl/sat_pkg.sv | 29 ++
 rtl/collision_scheduler_sq_unit.sv | 27 ++
 rtl/collision_scheduler.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/sat_pkg.sv
// Shared widths, body counts and scan FSM encoding for the collision scheduler.
package sat_pkg;

   localparam int unsigned NUM_BODIES  = 32;
   localparam int unsigned NUM_PLANETS = 8;
   localparam int unsigned COORD_W     = 10;
   localparam int unsigned RAD_W       = 6;
   localparam int unsigned IDX_W       = 5;

   // Squarer operand is a signed coordinate difference, one bit wider than a coordinate.
   localparam int unsigned SQ_IN_W     = COORD_W + 1;
   localparam int unsigned SQ_OUT_W    = 2 * SQ_IN_W;

   // Sum of two radii and its square.
   localparam int unsigned RS_W        = RAD_W + 1;
   localparam int unsigned RS2_W       = 2 * RS_W;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SNAP  = 3'd1,
      FETCH = 3'd2,
      SQX   = 3'd3,
      SQY   = 3'd4,
      SQR   = 3'd5,
      CMP   = 3'd6,
      DONE  = 3'd7
   } scan_state_t;

endpackage

// File: rtl/collision_scheduler_sq_unit.sv
// Registered squarer shared by the three squaring steps of each body test.
module sq_unit
   import sat_pkg::*;
(
   input  logic                       clk,
   input  logic                       rst,
   input  logic signed [SQ_IN_W-1:0]  a,
   output logic [SQ_OUT_W-1:0]        sq
);

   logic [SQ_IN_W-1:0] mag;

   // Take the magnitude first so the product is a plain unsigned multiply.
   always_comb begin
      mag = a[SQ_IN_W-1] ? $unsigned(-a) : $unsigned(a);
   end

   // One-cycle latency: result appears the cycle after the operand is presented.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sq <= '0;
      end else begin
         sq <= SQ_OUT_W'(mag) * SQ_OUT_W'(mag);
      end
   end

endmodule

// File: rtl/collision_scheduler.sv
// Per-frame scan of the body table testing vessel/body circle overlap.
module collision_scheduler #(
   parameter int unsigned NUM_BODIES  = sat_pkg::NUM_BODIES,
   parameter int unsigned NUM_PLANETS = sat_pkg::NUM_PLANETS
) (
   input  logic                          Clk,
   input  logic                          Reset,
   input  logic                          frame_clk,
   input  logic                          en,
   input  logic [2:0]                    curplan,
   input  logic [sat_pkg::COORD_W-1:0]   vessel_x,
   input  logic [sat_pkg::COORD_W-1:0]   vessel_y,
   input  logic [sat_pkg::RAD_W-1:0]     vessel_s,
   output logic [sat_pkg::IDX_W-1:0]     body_idx,
   input  logic [sat_pkg::COORD_W-1:0]   body_x,
   input  logic [sat_pkg::COORD_W-1:0]   body_y,
   input  logic [sat_pkg::RAD_W-1:0]     body_s,
   output logic                          busy,
   output logic                          done,
   output logic                          crash,
   output logic                          win,
   output logic                          overrun
);

   localparam int unsigned CW   = sat_pkg::COORD_W;
   localparam int unsigned RW   = sat_pkg::RAD_W;
   localparam int unsigned IW   = sat_pkg::IDX_W;
   localparam int unsigned SIW  = sat_pkg::SQ_IN_W;
   localparam int unsigned SOW  = sat_pkg::SQ_OUT_W;
   localparam int unsigned RSW  = sat_pkg::RS_W;
   localparam int unsigned RS2W = sat_pkg::RS2_W;

   sat_pkg::scan_state_t state, state_nxt;

   // frame_clk synchronizer and edge detector
   logic       sync1, sync2, sync3;
   logic [1:0] settle;
   logic       armed;
   logic       start;

   // snapshot of the vessel and the fetched body
   logic [CW-1:0] vx, vy, bx, by;
   logic [RW-1:0] vs, bs;
   logic [2:0]    cp;
   logic [IW-1:0] idx;

   // squaring datapath
   logic signed [SIW-1:0] dx, dy, sq_a;
   logic [RSW-1:0]        rs;
   logic [SOW-1:0]        sq, dx2, dy2, dist2;
   logic [RS2W-1:0]       rs2;
   logic                  overlap, is_target, last_body;

   logic acc_crash, acc_win;

   sq_unit u_sq (
      .clk (Clk),
      .rst (Reset),
      .a   (sq_a),
      .sq  (sq)
   );

   // Synchronize frame_clk; arm the edge detector only after a real low level
   // has been seen, so a frame_clk held high across Reset does not fire a scan.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         sync1  <= 1'b0;
         sync2  <= 1'b0;
         sync3  <= 1'b0;
         settle <= '0;
         armed  <= 1'b0;
      end else begin
         sync1 <= frame_clk;
         sync2 <= sync1;
         sync3 <= sync2;
         if (settle != 2'd2) begin
            settle <= settle + 2'd1;
         end else if (!sync2) begin
            armed <= 1'b1;
         end
      end
   end

   // Single-cycle start pulse on a synchronized rising edge.
   always_comb begin
      start = sync2 & ~sync3 & armed;
   end

   // Combinational geometry for the current body.
   always_comb begin
      dx        = {1'b0, vx} - {1'b0, bx};
      dy        = {1'b0, vy} - {1'b0, by};
      rs        = {1'b0, vs} + {1'b0, bs};
      rs2       = sq[RS2W-1:0];
      dist2     = dx2 + dy2;
      overlap   = (bs != '0) && (dist2 <= {{(SOW-RS2W){1'b0}}, rs2});
      is_target = (idx == {2'b00, cp}) && ({{(32-IW){1'b0}}, idx} < NUM_PLANETS);
      last_body = ({{(32-IW){1'b0}}, idx} >= NUM_BODIES - 1);
   end

   // FSM state register.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state <= sat_pkg::IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // FSM next-state logic; every state other than IDLE lasts one cycle.
   always_comb begin
      state_nxt = state;
      case (state)
         sat_pkg::IDLE:  if (start && en) state_nxt = sat_pkg::SNAP;
         sat_pkg::SNAP:  state_nxt = sat_pkg::FETCH;
         sat_pkg::FETCH: state_nxt = sat_pkg::SQX;
         sat_pkg::SQX:   state_nxt = sat_pkg::SQY;
         sat_pkg::SQY:   state_nxt = sat_pkg::SQR;
         sat_pkg::SQR:   state_nxt = sat_pkg::CMP;
         sat_pkg::CMP:   state_nxt = last_body ? sat_pkg::DONE : sat_pkg::FETCH;
         sat_pkg::DONE:  state_nxt = sat_pkg::IDLE;
         default:        state_nxt = sat_pkg::IDLE;
      endcase
   end

   // FSM outputs: busy window, table address and squarer operand select.
   always_comb begin
      busy     = 1'b0;
      body_idx = '0;
      sq_a     = '0;
      case (state)
         sat_pkg::SNAP:  busy = 1'b1;
         sat_pkg::FETCH: begin
            busy     = 1'b1;
            body_idx = idx;
         end
         sat_pkg::SQX: begin
            busy = 1'b1;
            sq_a = dx;
         end
         sat_pkg::SQY: begin
            busy = 1'b1;
            sq_a = dy;
         end
         sat_pkg::SQR: begin
            busy = 1'b1;
            sq_a = {{(SIW-RSW){1'b0}}, rs};
         end
         sat_pkg::CMP:   busy = 1'b1;
         default: ;
      endcase
   end

   // Scan datapath: snapshot, body fetch, squarer captures and accumulators.
   // rs2 is consumed straight from the squarer register during CMP.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         vx        <= '0;
         vy        <= '0;
         vs        <= '0;
         cp        <= '0;
         bx        <= '0;
         by        <= '0;
         bs        <= '0;
         idx       <= '0;
         dx2       <= '0;
         dy2       <= '0;
         acc_crash <= 1'b0;
         acc_win   <= 1'b0;
      end else begin
         case (state)
            sat_pkg::SNAP: begin
               vx        <= vessel_x;
               vy        <= vessel_y;
               vs        <= vessel_s;
               cp        <= curplan;
               idx       <= '0;
               acc_crash <= 1'b0;
               acc_win   <= 1'b0;
            end
            sat_pkg::FETCH: begin
               bx <= body_x;
               by <= body_y;
               bs <= body_s;
            end
            sat_pkg::SQY: dx2 <= sq;
            sat_pkg::SQR: dy2 <= sq;
            sat_pkg::CMP: begin
               if (overlap) begin
                  if (is_target) acc_win <= 1'b1;
                  else           acc_crash <= 1'b1;
               end
               if (!last_body) idx <= idx + 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Status outputs: results publish together with the done pulse; overrun is sticky.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         done    <= 1'b0;
         crash   <= 1'b0;
         win     <= 1'b0;
         overrun <= 1'b0;
      end else begin
         done <= (state == sat_pkg::DONE);
         if (state == sat_pkg::DONE) begin
            crash <= acc_crash;
            win   <= acc_win;
         end
         if (start && (state != sat_pkg::IDLE)) begin
            overrun <= 1'b1;
         end
      end
   end

endmodule
